// File: rtl/dual_issue_queue_pkg.sv
// Shared definitions for the dual-issue instruction queue.
//   - MIPS opcode / funct constants used by the pairing rules
//   - NOP_INSTR: encoding driven into an invalid decode slot
//   - q_entry_t: one queue entry {instruction, byte PC}
package dual_issue_queue_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0]  FUNCT_JR  = 6'h08;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } q_entry_t;

endpackage

// File: rtl/dual_issue_queue_dest.sv
// instr_dest_decode: classifies one instruction for the pairing check.
//   instr   in  32  instruction word
//   dest    out 5   register written (0 when the instruction writes none)
//   is_mem  out 1   lw or sw
//   is_ctrl out 1   beq, bne, j, jal or jr
module instr_dest_decode
   import dual_issue_queue_pkg::*;
(
   input  logic [31:0] instr,
   output logic [4:0]  dest,
   output logic        is_mem,
   output logic        is_ctrl
);

   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] shamt_unused;

   assign op           = instr[31:26];
   assign funct        = instr[5:0];
   assign shamt_unused = instr[10:6];

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
   always_comb begin
      dest = 5'd0;
      case (op)
         OP_RTYPE:                                         dest = instr[15:11];
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI, OP_LW: dest = instr[20:16];
         OP_JAL:                                           dest = 5'd31;
         default:                                          dest = 5'd0;
      endcase
   end

   assign is_mem  = (op == OP_LW) || (op == OP_SW);
   assign is_ctrl = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || (op == OP_JAL) ||
                    ((op == OP_RTYPE) && (funct == FUNCT_JR));

endmodule

// File: rtl/dual_issue_queue.sv
// dual_issue_queue: circular instruction buffer feeding a dual-issue decode register.
//   clk, rst_n                  clock, async active-low reset
//   fetch_valid/fetch_ready     pair handshake; ready while >= 2 entries are free
//   fetch_instr0/1, fetch_pc    instruction pair and byte PC of the first one
//   stalld                      hold decode register and head (enqueue still allowed)
//   flushd                      empty queue, bubble decode, drop same-cycle enqueue
//   instrd/instrd2              slot-0 / slot-1 instruction (0 when invalid)
//   pcplus4d/pcplus4d2          slot-0 / slot-1 PC+4
//   validd/validd2              slot-0 / slot-1 hold a real instruction
//   count                       occupied entries
module dual_issue_queue
   import dual_issue_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fetch_valid,
   output logic          fetch_ready,
   input  logic [31:0]   fetch_instr0,
   input  logic [31:0]   fetch_instr1,
   input  logic [31:0]   fetch_pc,
   input  logic          stalld,
   input  logic          flushd,
   output logic [31:0]   instrd,
   output logic [31:0]   instrd2,
   output logic [31:0]   pcplus4d,
   output logic [31:0]   pcplus4d2,
   output logic          validd,
   output logic          validd2,
   output logic [AW:0]   count
);

   q_entry_t      mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [AW-1:0] head_p1, tail_p1;
   q_entry_t      h0, h1;

   logic [4:0]    h0_dest;
   logic          h0_mem, h0_ctrl;
   logic [4:0]    h1_dest_unused;
   logic          h1_mem, h1_ctrl_unused;

   logic          has_two;
   logic          raw_hazard;
   logic          issue0, issue1;
   logic [1:0]    n_issue;
   logic          enq;
   logic [AW:0]   enq_amt, deq_amt;

   assign head_p1 = head + 1'b1;
   assign tail_p1 = tail + 1'b1;
   assign h0      = mem[head];
   assign h1      = mem[head_p1];

   instr_dest_decode u_dec_h0 (
      .instr   (h0.instr),
      .dest    (h0_dest),
      .is_mem  (h0_mem),
      .is_ctrl (h0_ctrl)
   );

   instr_dest_decode u_dec_h1 (
      .instr   (h1.instr),
      .dest    (h1_dest_unused),
      .is_mem  (h1_mem),
      .is_ctrl (h1_ctrl_unused)
   );

   assign fetch_ready = (count <= (AW+1)'(DEPTH - 2));
   assign enq         = fetch_valid && fetch_ready && !flushd;
   assign has_two     = (count >= (AW+1)'(2));

   // H1 reads (rs or rt) the register H0 writes; $0 never creates a dependency.
   assign raw_hazard = (h0_dest != 5'd0) &&
                       ((h1.instr[25:21] == h0_dest) || (h1.instr[20:16] == h0_dest));

   always_comb begin
      issue0 = 1'b0;
      issue1 = 1'b0;
      if (count != '0) begin
         issue0 = 1'b1;
         issue1 = has_two && !raw_hazard && !h0_ctrl && !(h0_mem && h1_mem);
      end
   end

   assign n_issue = {1'b0, issue0} + {1'b0, issue1};
   assign enq_amt = enq ? (AW+1)'(2) : '0;
   assign deq_amt = stalld ? '0 : (AW+1)'(n_issue);

   // NOTE: the entry array carries no reset; a slot is only read after it has been written, so clearing it buys nothing.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail]    <= '{instr: fetch_instr0, pc: fetch_pc};
         mem[tail_p1] <= '{instr: fetch_instr1, pc: fetch_pc + 32'd4};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flushd) begin
         head  <= tail;
         count <= '0;
      end else begin
         if (enq)     tail <= tail + AW'(2);
         if (!stalld) head <= head + AW'(n_issue);
         count <= count + enq_amt - deq_amt;
      end
   end

   // Decode pipeline register. Slot-1 PC+4 follows the second head entry whenever
   // one exists, even if that entry is held back for a later cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instrd    <= NOP_INSTR;
         instrd2   <= NOP_INSTR;
         pcplus4d  <= '0;
         pcplus4d2 <= '0;
         validd    <= 1'b0;
         validd2   <= 1'b0;
      end else if (flushd) begin
         instrd    <= NOP_INSTR;
         instrd2   <= NOP_INSTR;
         pcplus4d  <= '0;
         pcplus4d2 <= '0;
         validd    <= 1'b0;
         validd2   <= 1'b0;
      end else if (!stalld) begin
         instrd    <= issue0  ? h0.instr         : NOP_INSTR;
         pcplus4d  <= issue0  ? h0.pc + 32'd4    : '0;
         validd    <= issue0;
         instrd2   <= issue1  ? h1.instr         : NOP_INSTR;
         pcplus4d2 <= has_two ? h1.pc + 32'd4    : '0;
         validd2   <= issue1;
      end
   end

endmodule

// File: tb/tb_dual_issue_queue.sv
module tb_dual_issue_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_instr0, fetch_instr1, fetch_pc;
   logic        stalld, flushd;
   logic [31:0] instrd, instrd2, pcplus4d, pcplus4d2;
   logic        validd, validd2;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;

   dual_issue_queue #(.DEPTH(8), .AW(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetch_valid  (fetch_valid),
      .fetch_ready  (fetch_ready),
      .fetch_instr0 (fetch_instr0),
      .fetch_instr1 (fetch_instr1),
      .fetch_pc     (fetch_pc),
      .stalld       (stalld),
      .flushd       (flushd),
      .instrd       (instrd),
      .instrd2      (instrd2),
      .pcplus4d     (pcplus4d),
      .pcplus4d2    (pcplus4d2),
      .validd       (validd),
      .validd2      (validd2),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: a plain FIFO of {instr, pc} ----------------
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t        q[$];
   logic [31:0] e_instrd, e_instrd2, e_pc4, e_pc4_2;
   logic        e_v, e_v2;

   function automatic logic [4:0] m_dest(input logic [31:0] i);
      case (i[31:26])
         6'd0:                                return i[15:11];
         6'd8, 6'd10, 6'd12, 6'd13, 6'd15, 6'd35: return i[20:16];
         6'd3:                                return 5'd31;
         default:                             return 5'd0;
      endcase
   endfunction

   function automatic bit must_split(input logic [31:0] a, input logic [31:0] b);
      logic [5:0] oa, ob;
      logic [4:0] d;
      bit ctrl, mem2, raw;
      oa   = a[31:26];
      ob   = b[31:26];
      d    = m_dest(a);
      ctrl = (oa == 6'd4) || (oa == 6'd5) || (oa == 6'd2) || (oa == 6'd3) ||
             ((oa == 6'd0) && (a[5:0] == 6'd8));
      mem2 = ((oa == 6'd35) || (oa == 6'd43)) && ((ob == 6'd35) || (ob == 6'd43));
      raw  = (d != 5'd0) && ((b[25:21] == d) || (b[20:16] == d));
      return ctrl || mem2 || raw;
   endfunction

   always @(posedge clk) begin : model
      int n;
      bit rdy, i1;
      ent_t e;
      n   = q.size();
      rdy = (8 - n) >= 2;
      if (!rst_n || flushd) begin
         q.delete();
         e_instrd = 0; e_instrd2 = 0; e_pc4 = 0; e_pc4_2 = 0; e_v = 0; e_v2 = 0;
      end else begin
         if (!stalld) begin
            i1        = (n >= 2) && !must_split(q[0].instr, q[1].instr);
            e_v       = (n >= 1);
            e_instrd  = (n >= 1) ? q[0].instr : 32'h0;
            e_pc4     = (n >= 1) ? q[0].pc + 32'd4 : 32'h0;
            e_v2      = i1;
            e_instrd2 = i1 ? q[1].instr : 32'h0;
            e_pc4_2   = (n >= 2) ? q[1].pc + 32'd4 : 32'h0;
            if (n >= 1) void'(q.pop_front());
            if (i1)     void'(q.pop_front());
         end
         if (fetch_valid && rdy) begin
            e.instr = fetch_instr0; e.pc = fetch_pc;          q.push_back(e);
            e.instr = fetch_instr1; e.pc = fetch_pc + 32'd4;  q.push_back(e);
         end
      end
      #1;
      check("instrd",      instrd,            e_instrd);
      check("instrd2",     instrd2,           e_instrd2);
      check("pcplus4d",    pcplus4d,          e_pc4);
      check("pcplus4d2",   pcplus4d2,         e_pc4_2);
      check("validd",      32'(validd),       32'(e_v));
      check("validd2",     32'(validd2),      32'(e_v2));
      check("count",       32'(count),        32'(q.size()));
      check("fetch_ready", 32'(fetch_ready),  32'((8 - q.size()) >= 2));
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
      fetch_valid  = v;
      fetch_instr0 = i0;
      fetch_instr1 = i1;
      fetch_pc     = pc;
   endtask

   localparam int NTAB = 15;
   logic [31:0] tab0 [NTAB] = '{32'h30070001, 32'h34090001, 32'h280B0001, 32'h3C0D0001, 32'hAC090000,
                                32'h20000001, 32'h14220004, 32'h08000010, 32'h03E00008, 32'h0C000010,
                                32'h00211820, 32'h8C050000, 32'h8C050000, 32'hAC060004, 32'h20010005};
   logic [31:0] tab1 [NTAB] = '{32'h00074020, 32'h01205022, 32'h216C0001, 32'h01A07020, 32'h01205020,
                                32'h00000820, 32'h20040001, 32'h20040001, 32'h20040001, 32'h20040001,
                                32'hAC030000, 32'h00A03020, 32'h8C060000, 32'h8C070000, 32'h8C020000};

   initial begin
      rst_n = 1'b0; stalld = 1'b0; flushd = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step(); step();
      rst_n = 1'b1;
      check("reset_count", 32'(count), 32'd0);
      check("reset_ready", 32'(fetch_ready), 32'd1);

      // independent addi pair; no bypass into decode on the enqueue edge
      drive(1'b1, 32'h20010005, 32'h20020007, 32'h100);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      check("t2_nobypass", 32'(validd), 32'd0);
      step();
      check("t2_v2",   32'(validd2), 32'd1);
      check("t2_pc4",  pcplus4d,  32'h104);
      check("t2_pc42", pcplus4d2, 32'h108);

      // RAW through add: split over two cycles
      drive(1'b1, 32'h20010005, 32'h00211820, 32'h100);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
      check("t3_c1_instr", instrd, 32'h20010005);
      check("t3_c1_v2",    32'(validd2), 32'd0);
      step();
      check("t3_c2_instr", instrd, 32'h00211820);
      check("t3_c2_pc4",   pcplus4d, 32'h108);

      // branch issues alone
      drive(1'b1, 32'h10220004, 32'h20040001, 32'h300);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
      check("t4_beq",    instrd, 32'h10220004);
      check("t4_beq_v2", 32'(validd2), 32'd0);
      step();
      // lw ; sw split
      drive(1'b1, 32'h8C050000, 32'hAC060004, 32'h400);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
      check("t4_lw",    instrd, 32'h8C050000);
      check("t4_lw_v2", 32'(validd2), 32'd0);
      step();
      check("t4_sw",     instrd, 32'h8C050000 ^ 32'h20030004);
      check("t4_sw_pc4", pcplus4d, 32'h408);

      // fill under stall, then drain
      stalld = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h20000000 | (32'(2*k+1) << 16), 32'h20000000 | (32'(2*k+2) << 16), 32'h500 + 32'(8*k));
         step();
      end
      check("t5_full",  32'(count), 32'd8);
      check("t5_ready", 32'(fetch_ready), 32'd0);
      step();   // offer refused while full
      check("t5_refuse", 32'(count), 32'd8);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      stalld = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("t5_drain", 32'(count), 32'(6 - 2*k));
      end

      // flush beats stall and same-cycle enqueue
      stalld = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h20010005, 32'h20020007, 32'h600 + 32'(8*k));
         step();
      end
      check("t6_count6", 32'(count), 32'd6);
      flushd = 1'b1;
      drive(1'b1, 32'h20030001, 32'h20040001, 32'h700);
      step();
      flushd = 1'b0; stalld = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      check("t6_count",  32'(count), 32'd0);
      check("t6_instrd", instrd, 32'h0);
      check("t6_validd", 32'(validd), 32'd0);
      step();
      check("t6_dropped", 32'(validd), 32'd0);

      // reset mid-stream with 5 entries queued
      stalld = 1'b1;
      drive(1'b1, 32'h20010005, 32'h00211820, 32'h800);
      step();
      drive(1'b1, 32'h20020007, 32'h20050001, 32'h808);
      step();
      drive(1'b1, 32'h20060001, 32'h20070001, 32'h810);
      step();
      stalld = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
      check("t1_five", 32'(count), 32'd5);
      rst_n = 1'b0;
      #1;
      check("t1_async_count", 32'(count), 32'd0);
      check("t1_async_valid", 32'(validd), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("t1_ready",  32'(fetch_ready), 32'd1);
      check("t1_valid2", 32'(validd2), 32'd0);

      // pairing-rule table, one pair at a time, checked by the model every cycle
      for (int k = 0; k < NTAB; k++) begin
         drive(1'b1, tab0[k], tab1[k], 32'h1000 + 32'(16*k));
         step();
         drive(1'b0, 32'h0, 32'h0, 32'h0);
         step(); step();
      end
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
